// File: rtl/pacman_pkg.sv
// Shared definitions for the player movement controller:
// direction encodings, helper functions and FSM state type.
package pacman_pkg;

   localparam int TILE_COLS = 42;

   localparam int DIR_LEFT  = 0;
   localparam int DIR_RIGHT = 1;
   localparam int DIR_UP    = 2;
   localparam int DIR_DOWN  = 3;

   localparam logic [3:0] D_LEFT  = 4'b0001;
   localparam logic [3:0] D_RIGHT = 4'b0010;
   localparam logic [3:0] D_UP    = 4'b0100;
   localparam logic [3:0] D_DOWN  = 4'b1000;

   typedef enum logic {
      CENTER,
      STEP
   } mv_state_t;

   function automatic logic [3:0] dir_opposite(
      input logic [3:0] d
   );
      return {d[DIR_UP], d[DIR_DOWN],
              d[DIR_LEFT], d[DIR_RIGHT]};
   endfunction

   function automatic logic is_onehot4(
      input logic [3:0] d
   );
      return (d != 4'b0) &&
             ((d & (d - 4'b1)) == 4'b0);
   endfunction

endpackage

// File: rtl/pacman_move_ctrl_if.sv
// Movement controller bus: strobes, requests and walk mask in,
// tile coordinates, sub-tile offset and status out.
interface pacman_move_ctrl_if #(
   parameter int OFF_W = 4
);

   logic             move_tick;
   logic             pause;
   logic [3:0]       dir_req;
   logic             dir_req_valid;
   logic [3:0]       valid;
   logic [9:0]       block_x_reg;
   logic [9:0]       block_y_reg;
   logic [OFF_W-1:0] sub_off;
   logic [3:0]       cur_dir;
   logic             moving;
   logic             tile_enter;
   logic             stuck_err;

   modport master (
      output move_tick, pause, dir_req,
      output dir_req_valid, valid,
      input  block_x_reg, block_y_reg, sub_off,
      input  cur_dir, moving, tile_enter, stuck_err
   );

   modport slave (
      input  move_tick, pause, dir_req,
      input  dir_req_valid, valid,
      output block_x_reg, block_y_reg, sub_off,
      output cur_dir, moving, tile_enter, stuck_err
   );

endinterface

// File: rtl/pacman_dir_sel.sv
// Centre-of-tile direction choice: take the request if the tile
// allows it, else keep going straight if possible.
module pacman_dir_sel (
   input  logic [3:0] eff,
   input  logic [3:0] cur_dir,
   input  logic [3:0] valid,
   output logic [3:0] nxt_dir,
   output logic       go,
   output logic       take
);

   assign take    = |(eff & valid);
   assign go      = take | (|(cur_dir & valid));
   assign nxt_dir = take ? eff : cur_dir;

endmodule

// File: rtl/pacman_move_ctrl.sv
// Player sprite movement: owns tile coordinates, buffers turns
// until a tile centre, steps STEP_DIV ticks per tile.
module pacman_move_ctrl
   import pacman_pkg::*;
#(
   parameter int START_X  = 19,
   parameter int START_Y  = 27,
   parameter int STEP_DIV = 8,
   parameter int OFF_W    = 4
) (
   input logic               clk,
   input logic               rst_n,
   pacman_move_ctrl_if.slave bus
);

   localparam logic [OFF_W-1:0] LAST =
      OFF_W'(STEP_DIV - 1);
   localparam logic [OFF_W-1:0] ONE = OFF_W'(1);

   mv_state_t        state_q, state_d;
   logic [9:0]       x_q, x_d;
   logic [9:0]       y_q, y_d;
   logic [OFF_W-1:0] off_q, off_d;
   logic [3:0]       dir_q, dir_d;
   logic [3:0]       pend_q, pend_d;
   logic             mov_q, mov_d;
   logic             te_q, te_d;
   logic             stk_q, stk_d;

   logic             req_ok;
   logic             adv;
   logic [3:0]       eff;
   logic [3:0]       nxt_dir;
   logic             go;
   logic             take;

   // A fresh one-hot request bypasses the buffer this cycle.
   assign req_ok = bus.dir_req_valid &
                   is_onehot4(bus.dir_req);
   assign eff    = req_ok ? bus.dir_req : pend_q;
   assign adv    = bus.move_tick & ~bus.pause;

   pacman_dir_sel u_sel (
      .eff     (eff),
      .cur_dir (dir_q),
      .valid   (bus.valid),
      .nxt_dir (nxt_dir),
      .go      (go),
      .take    (take)
   );

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      off_d   = off_q;
      dir_d   = dir_q;
      mov_d   = mov_q;
      te_d    = 1'b0;
      pend_d  = req_ok ? bus.dir_req : pend_q;
      stk_d   = stk_q |
                ((state_q == CENTER) &&
                 (bus.valid == 4'b0));
      unique case (state_q)
         CENTER: begin
            if (adv) begin
               if (go) begin
                  dir_d   = nxt_dir;
                  mov_d   = 1'b1;
                  off_d   = ONE;
                  state_d = STEP;
                  if (take) pend_d = 4'b0;
               end else begin
                  mov_d = 1'b0;
               end
            end
         end
         STEP: begin
            if (adv) begin
               if (off_q == LAST) begin
                  off_d   = '0;
                  te_d    = 1'b1;
                  state_d = CENTER;
                  unique case (1'b1)
                     dir_q[DIR_RIGHT]: x_d = x_q + 10'd1;
                     dir_q[DIR_LEFT]:  x_d = x_q - 10'd1;
                     dir_q[DIR_DOWN]:  y_d = y_q + 10'd1;
                     dir_q[DIR_UP]:    y_d = y_q - 10'd1;
                     default: ;
                  endcase
               end else begin
                  off_d = off_q + ONE;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CENTER;
         x_q     <= 10'(START_X);
         y_q     <= 10'(START_Y);
         off_q   <= '0;
         dir_q   <= 4'b0;
         pend_q  <= 4'b0;
         mov_q   <= 1'b0;
         te_q    <= 1'b0;
         stk_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         off_q   <= off_d;
         dir_q   <= dir_d;
         pend_q  <= pend_d;
         mov_q   <= mov_d;
         te_q    <= te_d;
         stk_q   <= stk_d;
      end
   end

   assign bus.block_x_reg = x_q;
   assign bus.block_y_reg = y_q;
   assign bus.sub_off     = off_q;
   assign bus.cur_dir     = dir_q;
   assign bus.moving      = mov_q;
   assign bus.tile_enter  = te_q;
   assign bus.stuck_err   = stk_q;

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Bench for pacman_move_ctrl: directed maze walk with literal
// checks, then random traffic against a behavioural model.
module tb_pacman_move_ctrl;
   import pacman_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pacman_move_ctrl_if #(.OFF_W(4)) bus ();

   pacman_move_ctrl #(
      .START_X  (19),
      .START_Y  (27),
      .STEP_DIV (8),
      .OFF_W    (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_on = 1'b0;
   bit force0 = 1'b0;

   // Maze: rows 1 and 27 (cols 2..40), cols 2,19,40 (rows 1..27)
   function automatic bit walk(int x, int y);
      return (y == 27 && x >= 2 && x <= 40) ||
             (y == 1 && x >= 2 && x <= 40) ||
             ((x == 2 || x == 19 || x == 40) &&
              y >= 1 && y <= 27);
   endfunction

   function automatic logic [3:0] mask(int x, int y);
      return {walk(x, y + 1), walk(x, y - 1),
              walk(x + 1, y), walk(x - 1, y)};
   endfunction

   always_comb
      bus.valid = force0 ? 4'b0 :
         mask(int'(bus.block_x_reg), int'(bus.block_y_reg));

   // Behavioural model: position, progress within tile, heading.
   int         m_x, m_y, m_k;
   logic [3:0] m_dir, m_pend;
   bit         m_mov, m_te, m_stk;

   task automatic model_reset();
      m_x = 19; m_y = 27; m_k = 0;
      m_dir = 4'b0; m_pend = 4'b0;
      m_mov = 0; m_te = 0; m_stk = 0;
   endtask

   function automatic int dxy(logic [3:0] d, bit vert);
      int r;
      r = 0;
      if (!vert && d == 4'b0001) r = -1;
      if (!vert && d == 4'b0010) r = 1;
      if (vert && d == 4'b0100) r = -1;
      if (vert && d == 4'b1000) r = 1;
      return r;
   endfunction

   task automatic chk(input string nm, input int act,
                      input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, predict, advance to next negedge.
   task automatic cyc(input bit mt, input bit ps,
                      input logic [3:0] rq, input bit rv);
      logic [3:0] v, eff, np, nd;
      int nx, ny, nk;
      bit nm, nt, ns, fresh;
      bus.move_tick = mt;
      bus.pause = ps;
      bus.dir_req = rq;
      bus.dir_req_valid = rv;
      #1;
      v = bus.valid;
      nx = m_x; ny = m_y; nk = m_k;
      nd = m_dir; nm = m_mov; nt = 0; ns = m_stk;
      fresh = rv && ($countones(rq) == 1);
      np = fresh ? rq : m_pend;
      eff = fresh ? rq : m_pend;
      if (m_k == 0 && v == 4'b0) ns = 1;
      if (mt && !ps) begin
         if (m_k == 0) begin
            if ((eff & v) != 0) begin
               nd = eff; np = 4'b0; nk = 1; nm = 1;
            end else if ((m_dir & v) != 0) begin
               nk = 1; nm = 1;
            end else begin
               nm = 0;
            end
         end else if (m_k + 1 < 8) begin
            nk = m_k + 1;
         end else begin
            nk = 0; nt = 1;
            nx = m_x + dxy(m_dir, 0);
            ny = m_y + dxy(m_dir, 1);
         end
      end
      @(posedge clk);
      m_x = nx; m_y = ny; m_k = nk; m_dir = nd;
      m_pend = np; m_mov = nm; m_te = nt; m_stk = ns;
      @(negedge clk);
   endtask

   task automatic tick(input int n);
      repeat (n) cyc(1, 0, 4'b0, 0);
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_x", int'(bus.block_x_reg), 19);
      chk("rst_y", int'(bus.block_y_reg), 27);
      chk("rst_off", int'(bus.sub_off), 0);
      chk("rst_dir", int'(bus.cur_dir), 0);
      chk("rst_mov", int'(bus.moving), 0);
      chk("rst_stk", int'(bus.stuck_err), 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("x", int'(bus.block_x_reg), m_x);
         chk("y", int'(bus.block_y_reg), m_y);
         chk("sub_off", int'(bus.sub_off), m_k);
         chk("cur_dir", int'(bus.cur_dir), int'(m_dir));
         chk("moving", int'(bus.moving), int'(m_mov));
         chk("tile_enter", int'(bus.tile_enter), int'(m_te));
         chk("stuck_err", int'(bus.stuck_err), int'(m_stk));
      end
   end

   initial begin
      logic [3:0] rq;
      bit mt, ps, rv;
      bus.move_tick = 0;
      bus.pause = 0;
      bus.dir_req = 4'b0;
      bus.dir_req_valid = 0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      chk("init_x", int'(bus.block_x_reg), 19);
      chk("init_y", int'(bus.block_y_reg), 27);
      chk("init_dir", int'(bus.cur_dir), 0);
      chk("init_stk", int'(bus.stuck_err), 0);
      chk_on = 1'b1;

      // First tile left
      cyc(0, 0, D_LEFT, 1);
      tick(7);
      chk("walk_off7", int'(bus.sub_off), 7);
      chk("walk_x19", int'(bus.block_x_reg), 19);
      tick(1);
      chk("walk_x18", int'(bus.block_x_reg), 18);
      chk("walk_te", int'(bus.tile_enter), 1);
      chk("walk_off0", int'(bus.sub_off), 0);
      cyc(0, 0, 4'b0, 0);
      chk("walk_te_off", int'(bus.tile_enter), 0);

      // Run to the west wall and stop
      tick(136);
      chk("wall_x", int'(bus.block_x_reg), 2);
      chk("wall_mov", int'(bus.moving), 0);

      // Reversal requested mid-tile
      cyc(0, 0, D_RIGHT, 1);
      tick(28);
      chk("rev_x5", int'(bus.block_x_reg), 5);
      chk("rev_off4", int'(bus.sub_off), 4);
      cyc(0, 0, D_LEFT, 1);
      tick(4);
      chk("rev_x6", int'(bus.block_x_reg), 6);
      chk("rev_dir_r", int'(bus.cur_dir), 2);
      tick(1);
      chk("rev_dir_l", int'(bus.cur_dir), 1);
      chk("rev_off1", int'(bus.sub_off), 1);

      // Pre-turn up, held until (2,27)
      tick(7);
      tick(3);
      cyc(0, 0, D_UP, 1);
      tick(21);
      chk("pre_x2", int'(bus.block_x_reg), 2);
      chk("pre_dir_l", int'(bus.cur_dir), 1);
      tick(8);
      chk("pre_y26", int'(bus.block_y_reg), 26);
      chk("pre_dir_u", int'(bus.cur_dir), 4);

      // Same-cycle bypass, then pause
      cyc(1, 0, D_DOWN, 1);
      chk("byp_dir", int'(bus.cur_dir), 8);
      chk("byp_off", int'(bus.sub_off), 1);
      repeat (10) cyc(1, 1, 4'b0, 0);
      chk("pause_off", int'(bus.sub_off), 1);
      chk("pause_y", int'(bus.block_y_reg), 26);

      // Asynchronous reset mid-step
      tick(4);
      chk("mid_off5", int'(bus.sub_off), 5);
      async_reset();

      // Empty mask at a centre
      force0 = 1'b1;
      cyc(0, 0, 4'b0, 0);
      chk("stuck_set", int'(bus.stuck_err), 1);
      cyc(1, 0, D_LEFT, 1);
      chk("stuck_x", int'(bus.block_x_reg), 19);
      chk("stuck_mov", int'(bus.moving), 0);
      force0 = 1'b0;
      cyc(0, 0, 4'b0, 0);
      chk("stuck_hold", int'(bus.stuck_err), 1);
      async_reset();

      // Random traffic
      repeat (1500) begin
         mt = ($urandom_range(0, 2) == 0);
         ps = ($urandom_range(0, 7) == 0);
         rv = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 3) != 0) begin
            rq = 4'b0001 << $urandom_range(0, 3);
         end else begin
            rq = 4'($urandom);
         end
         cyc(mt, ps, rq, rv);
      end

      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pacman_move_ctrl.md
Name: pacman_move_ctrl

Overview:
Sequential movement controller for the player sprite in the maze. It owns the player's tile coordinates (block_x_reg, block_y_reg), which drive walk_detect. It consumes walk_detect's 4-bit valid mask for the current tile and uses it to accept, buffer or reject direction requests. It advances the sprite one sub-tile step per move_tick and reports a fine pixel offset to the renderer.

Parameters:
START_X, 19, reset tile column (0..41).
START_Y, 27, reset tile row (0..29).
STEP_DIV, 8, move_ticks per tile (power of two, 2..16).
OFF_W, 4, width of sub_off; must hold STEP_DIV-1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
move_tick  in  1  one-cycle movement strobe, typically once per frame
pause  in  1  freeze all motion while high
dir_req  in  4  requested direction, one-hot: bit3 down, bit2 up, bit1 right, bit0 left
dir_req_valid  in  1  qualifies dir_req for one cycle
valid  in  4  allowed exits of the current tile, from walk_detect (same bit order)
block_x_reg  out  10  current tile column, fed to walk_detect
block_y_reg  out  10  current tile row, fed to walk_detect
sub_off  out  OFF_W  steps travelled from the current tile centre toward cur_dir
cur_dir  out  4  one-hot direction of travel; 0 means never moved
moving  out  1  sprite is in motion
tile_enter  out  1  one-cycle pulse when the coordinates change
stuck_err  out  1  sticky flag: the current tile has an all-zero valid mask

Behaviour:
- Reset (asynchronous, rst_n low):
  - block_x_reg = START_X, block_y_reg = START_Y.
  - sub_off = 0, cur_dir = 0, moving = 0, tile_enter = 0, stuck_err = 0.
  - pending register cleared, FSM in CENTER.
  - Asserting rst_n low mid-move returns to these values immediately; there is no partial step.
- Request buffer:
  - On dir_req_valid with a one-hot dir_req, latch dir_req into pending. A newer request overwrites an older one.
  - A dir_req that is not one-hot is ignored and pending is unchanged.
  - pending is held until it is consumed at a tile centre.
- Effective request: eff = dir_req if it is valid and one-hot this cycle, otherwise pending. This gives same-cycle bypass.
- FSM state CENTER (sub_off == 0):
  - Action on move_tick with pause low:
    - If eff & valid is nonzero: set cur_dir = eff, clear pending, set moving = 1, set sub_off = 1, go to STEP.
    - Else if cur_dir & valid is nonzero: keep cur_dir and pending, set moving = 1, set sub_off = 1, go to STEP.
    - Else: set moving = 0, stay in CENTER, keep cur_dir and pending. This is the wall stop.
  - If valid == 0 in CENTER, set stuck_err. It is cleared only by reset. Motion stays inhibited because no request can match an empty mask.
- FSM state STEP (0 < sub_off < STEP_DIV):
  - On move_tick with pause low and sub_off < STEP_DIV-1: sub_off increments by 1.
  - On move_tick with pause low and sub_off == STEP_DIV-1, update the coordinate by one tile:
    - right: x+1
    - left: x-1
    - down: y+1
    - up: y-1
  - In the same cycle: sub_off = 0, tile_enter = 1 for that cycle, next state CENTER.
  - Direction changes, including reversal, are never applied mid-tile. They stay in pending until the next centre.
- Latency:
  - A request made at a centre takes effect on the same move_tick.
  - The coordinate changes exactly STEP_DIV move_ticks after leaving the centre.
  - valid is combinational from the new coordinates and is assumed settled by the next move_tick.
- pause high: move_tick is ignored and all state holds. Requests are still latched into pending.
- Arithmetic: 10-bit unsigned coordinates. The maze mask prevents leaving 1..40, so no wrap logic is required. Coordinates only change through the transitions above.
- moving stays 1 through STEP and through centres passed without stopping.

Decomposition:
- Shared package pacman_pkg:
  - DIR_LEFT/RIGHT/UP/DOWN bit indices and one-hot constants.
  - dir_opposite function.
  - is_onehot4 function.
  - TILE_COLS = 42.
  - FSM state typedef {CENTER, STEP}.
- One sub-module is natural: pacman_dir_sel, a combinational function of eff, cur_dir and valid that returns the next direction and a go flag. All registers stay in pacman_move_ctrl.

Test Plan:
- Reset at (19,27) (valid 0111). Request left, then 8 move_ticks -> block_x_reg=18, tile_enter pulses once, sub_off walks 1..7 then 0.
- Keep moving left along row 27 to (2,27) (valid 0110) -> motion stops there, moving=0, block_x_reg stays 2 on further ticks.
- Pre-turn: moving left from x=5, row 27; request up at sub_off=3 -> continues left through x=3 (0011). Turns at (2,27): y becomes 26 after 8 more ticks, pending cleared.
- Reversal mid-tile: moving right at sub_off=4; request left -> sub_off continues to 7, x increments. Direction flips to left only at the next centre.
- Bypass plus pause: dir_req_valid in the same cycle as move_tick at the centre -> accepted that tick. With pause=1, 10 move_ticks produce no change in x, y or sub_off.
- Reset mid-STEP at sub_off=5 with rst_n pulsed low -> outputs return to (19,27), sub_off=0, cur_dir=0 with no clock edge needed. Forcing valid=0 at a centre -> stuck_err=1 and no motion.
